rcv_ctrl: RTL and testbench
===========================

Name: rcv_ctrl

Overview:
- Receive control unit for the USB-style serial receiver.
- Sequences the bit timer and shift register through a packet: detects packet start, validates the SYNC byte, issues one-cycle FIFO write strobes per data byte, and validates end-of-packet alignment.
- Sits between the edge detector/EOP detector and the timer, shift register and receive FIFO.
- Drives `rcving` (timer enable), which gates the bit timer.

Parameters:
- SYNC_BYTE, 8'h80, byte value `rcv_data` must equal after the first `byte_received` of a packet.
- MAX_BYTES, 64, maximum data bytes per packet (SYNC excluded); the next byte beyond this is an error.
- CNT_W, 7, width of `byte_count`; must satisfy 2**CNT_W > MAX_BYTES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- d_edge  input  1  one-cycle pulse on any data-line transition.
- eop  input  1  level, high while line is in SE0.
- shift_enable  input  1  one-cycle bit-sample pulse from timer.
- byte_received  input  1  one-cycle pulse from timer after 8th bit shifted.
- rcv_data  input  8  parallel byte from shift register; valid the cycle `byte_received` is high.
- rcving  output  1  packet in progress; enables timer.
- w_enable  output  1  one-cycle FIFO write strobe.
- r_error  output  1  sticky receive-error flag.
- byte_count  output  CNT_W  data bytes written in current packet.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a rising edge) forces state IDLE and all outputs low: `rcving`=0, `w_enable`=0, `r_error`=0, `byte_count`=0. This applies from any state, including mid-packet.
- All outputs are registered (Moore); each output changes one cycle after the triggering input.
- Bit-phase tracking:
  - Internal `mid_byte` is set on `shift_enable` and cleared on `byte_received`; it is cleared in IDLE.
  - If both pulse in the same cycle, clear wins.
- IDLE: `rcving`=0.
  - `d_edge`=1 → SYNC.
  - On entry from IDLE, `r_error` and `byte_count` clear the same cycle.
- SYNC: `rcving`=1.
  - `byte_received`=1 → SYNC_CHK.
  - `eop` with `shift_enable` → ERR.
- SYNC_CHK (1 cycle): `rcv_data`, registered at `byte_received`, is compared to SYNC_BYTE.
  - Equal → RCV.
  - Not equal → ERR.
- RCV: `rcving`=1.
  - `byte_received`=1 and `byte_count` < MAX_BYTES → STORE.
  - `byte_received`=1 and `byte_count` = MAX_BYTES → ERR.
  - `eop`=1 and `shift_enable`=1 → EOP_CHK.
  - If `byte_received` and `eop`+`shift_enable` occur in the same cycle, `byte_received` takes priority and `eop` is re-evaluated in STORE's successor.
- STORE (1 cycle): `w_enable`=1, `byte_count` increments; then → RCV.
- EOP_CHK (1 cycle):
  - `mid_byte`=0 → EOP_WAIT (clean end).
  - `mid_byte`=1 → ERR (partial byte).
  - A packet with `byte_count`=0 at EOP is legal (no error).
- EOP_WAIT: `rcving`=0.
  - `d_edge`=1 (SE0→idle J) → IDLE.
- ERR: `r_error`=1, `rcving`=0, no further `w_enable`.
  - Waits for `eop`=0 followed by `d_edge`=1 → EIDLE.
  - `d_edge` while `eop`=1 is ignored.
- EIDLE: `r_error` held at 1.
  - `d_edge`=1 → SYNC; `r_error` clears on that transition.
- `byte_count` saturates at MAX_BYTES and never wraps.
- `w_enable` is never high for two consecutive cycles.
- `w_enable` is never asserted for the SYNC byte.

Optional Feature:
- Macro: RCV_CTRL_PID_CHECK_EN.
- When defined:
  - The first data byte after SYNC is PID-checked: `rcv_data[7:4]` must equal `~rcv_data[3:0]`.
  - On pass → STORE as normal.
  - On fail → ERR, with no `w_enable` for that byte.
  - The check adds a PID_CHK state (1 cycle) between RCV and STORE, used only for byte 0.
- When undefined: every data byte goes straight to STORE with no PID check, and the PID_CHK state is absent.

Test Plan:
- Reset mid-RCV (rst=1 for 1 cycle) → next cycle: state IDLE, `rcving`=0, `r_error`=0, `byte_count`=0, `w_enable`=0.
- `d_edge`, SYNC 8'h80, data bytes 8'hA5, 8'h3C, then `eop`+`shift_enable` with `mid_byte`=0, then `d_edge` → exactly 2 single-cycle `w_enable` pulses, `byte_count`=2, `r_error`=0, `rcving` falls after EOP, returns to IDLE.
- SYNC byte 8'h81 → `r_error`=1 two cycles after `byte_received`, `rcving`=0, no `w_enable`; `eop` low then `d_edge` → EIDLE with `r_error` still 1; next `d_edge` → `r_error`=0, `rcving`=1.
- Valid SYNC, 3 bits of a data byte shifted, then `eop`+`shift_enable` → `r_error`=1, `byte_count` unchanged.
- MAX_BYTES=2, send 3 data bytes → 2 `w_enable` pulses, third `byte_received` → `r_error`=1, `byte_count` stays 2.
- With RCV_CTRL_PID_CHECK_EN: first byte 8'hE1 → stored; first byte 8'hE2 → ERR, zero `w_enable` pulses.

Source files
------------

// File: rtl/rcv_ctrl.sv
// Receive control FSM: start detect, SYNC check, per-byte FIFO write strobes, EOP alignment check.
// Latency: all outputs registered, changing one cycle after the triggering input.
// Backpressure: none (FIFO is write-only strobed); define RCV_CTRL_PID_CHECK_EN to PID-check data byte 0.
module rcv_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64,
    parameter int         CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        SYNC_CHK,
        RCV,
        STORE,
        EOP_CHK,
        EOP_WAIT,
        ERR,
        EIDLE
`ifdef RCV_CTRL_PID_CHECK_EN
        , PID_CHK
`endif
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             mid_byte_q, mid_byte_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic             rcving_q, rcving_d;
    logic             w_enable_q, w_enable_d;
    logic             r_error_q, r_error_d;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        mid_byte_d   = mid_byte_q;
        byte_count_d = byte_count_q;

        if (byte_received) begin
            data_d = rcv_data;
        end

        // The SE0 sample that signals EOP is not a data bit, so it must not mark a partial byte.
        if (state_q == IDLE || byte_received) begin
            mid_byte_d = 1'b0;
        end else if (shift_enable && !eop) begin
            mid_byte_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (d_edge) state_d = SYNC;
            end
            SYNC: begin
                if (byte_received)             state_d = SYNC_CHK;
                else if (eop && shift_enable)  state_d = ERR;
            end
            SYNC_CHK: begin
                state_d = (data_q == SYNC_BYTE) ? RCV : ERR;
            end
            RCV: begin
                if (byte_received) begin
                    if (byte_count_q >= MAX_CNT) begin
                        state_d = ERR;
                    end else begin
`ifdef RCV_CTRL_PID_CHECK_EN
                        state_d = (byte_count_q == '0) ? PID_CHK : STORE;
`else
                        state_d = STORE;
`endif
                    end
                end else if (eop && shift_enable) begin
                    state_d = EOP_CHK;
                end
            end
`ifdef RCV_CTRL_PID_CHECK_EN
            PID_CHK: begin
                state_d = (data_q[7:4] == ~data_q[3:0]) ? STORE : ERR;
            end
`endif
            STORE: begin
                state_d = RCV;
            end
            EOP_CHK: begin
                state_d = mid_byte_q ? ERR : EOP_WAIT;
            end
            EOP_WAIT: begin
                if (d_edge) state_d = IDLE;
            end
            ERR: begin
                if (d_edge && !eop) state_d = EIDLE;
            end
            EIDLE: begin
                if (d_edge) state_d = SYNC;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new packet starts with a fresh count; STORE is only ever entered below MAX_BYTES.
        if (state_d == SYNC && state_q != SYNC) begin
            byte_count_d = '0;
        end else if (state_d == STORE && byte_count_q < MAX_CNT) begin
            byte_count_d = byte_count_q + CNT_ONE;
        end

        rcving_d   = (state_d == SYNC) || (state_d == SYNC_CHK) ||
                     (state_d == RCV)  || (state_d == STORE)
`ifdef RCV_CTRL_PID_CHECK_EN
                     || (state_d == PID_CHK)
`endif
                     ;
        w_enable_d = (state_d == STORE);
        r_error_d  = (state_d == ERR) || (state_d == EIDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            mid_byte_q   <= 1'b0;
            byte_count_q <= '0;
            rcving_q     <= 1'b0;
            w_enable_q   <= 1'b0;
            r_error_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            mid_byte_q   <= mid_byte_d;
            byte_count_q <= byte_count_d;
            rcving_q     <= rcving_d;
            w_enable_q   <= w_enable_d;
            r_error_q    <= r_error_d;
        end
    end

    assign rcving     = rcving_q;
    assign w_enable   = w_enable_q;
    assign r_error    = r_error_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rcv_ctrl.sv
// Bench for rcv_ctrl: packet-level stimulus, expected FIFO writes queued per packet and
// checked by an independent w_enable monitor; packet outcome checked after each packet.
module tb_rcv_ctrl;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam int         MAXB      = 2;
    localparam int         CNT_W     = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             d_edge;
    logic             eop;
    logic             shift_enable;
    logic             byte_received;
    logic [7:0]       rcv_data;
    logic             rcving;
    logic             w_enable;
    logic             r_error;
    logic [CNT_W-1:0] byte_count;

    int total = 0;
    int bad   = 0;

    int         exp_q[$];
    logic [7:0] pkt_q[$];
    logic       prev_we = 1'b0;

    rcv_ctrl #(
        .SYNC_BYTE (SYNC_BYTE),
        .MAX_BYTES (MAXB),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int gap();
        return int'($urandom_range(3, 5));
    endfunction

`ifdef RCV_CTRL_PID_CHECK_EN
    function automatic bit pid_ok(input logic [7:0] d);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = d[7:4];
        lo = d[3:0];
        return (hi ^ lo) == 4'hF;
    endfunction
`endif

    task automatic shift_pulse();
        shift_enable = 1'b1;
        tick(1);
        shift_enable = 1'b0;
        tick(gap());
    endtask

    task automatic edge_pulse();
        d_edge = 1'b1;
        tick(1);
        d_edge = 1'b0;
    endtask

    // Eight bit samples then the byte strobe; sometimes the strobe lands on the 8th sample.
    task automatic send_byte(input logic [7:0] b);
        bit same;
        same = 1'($urandom_range(0, 1));
        for (int i = 0; i < 7; i++) shift_pulse();
        shift_enable = 1'b1;
        if (same) begin
            byte_received = 1'b1;
            rcv_data      = b;
        end
        tick(1);
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        if (!same) begin
            rcv_data      = b;
            byte_received = 1'b1;
            tick(1);
            byte_received = 1'b0;
        end
        rcv_data = $urandom_range(0, 255);
        tick(gap());
    endtask

    task automatic start_pkt();
        edge_pulse();
        tick(2);
        check("start_rcving", rcving, 1);
        check("start_err", r_error, 0);
        check("start_cnt", byte_count, 0);
    endtask

    task automatic end_pkt(input bit err, input int cnt);
        eop          = 1'b1;
        shift_enable = 1'b1;
        tick(1);
        shift_enable = 1'b0;
        tick(3);
        check("eop_rcving", rcving, 0);
        check("eop_err", r_error, err);
        tick(1);
        eop = 1'b0;
        tick(2);
        edge_pulse();
        tick(2);
        check("end_err", r_error, err);
        check("end_rcving", rcving, 0);
        check("end_cnt", byte_count, cnt);
        check("end_wen", w_enable, 0);
    endtask

    // Reference outcome from the packet contents: which bytes are written and whether it errs.
    task automatic run_pkt(input logic [7:0] sync, input int partial);
        bit err;
        int cnt;
        err = (sync != SYNC_BYTE);
        cnt = 0;
        for (int i = 0; i < pkt_q.size() && !err; i++) begin
            if (i >= MAXB) err = 1'b1;
`ifdef RCV_CTRL_PID_CHECK_EN
            else if (i == 0 && !pid_ok(pkt_q[i])) err = 1'b1;
`endif
            else begin
                cnt++;
                exp_q.push_back(cnt);
            end
        end
        if (!err && partial != 0) err = 1'b1;

        start_pkt();
        send_byte(sync);
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        repeat (partial) shift_pulse();
        end_pkt(err, cnt);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (w_enable === 1'b1) begin
                check("wen_single", prev_we, 0);
                check("wen_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("wen_count", byte_count, exp_q.pop_front());
            end
            prev_we = w_enable;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        rcv_data      = 8'h00;
        tick(2);
        rst = 1'b0;
        check("rst_rcving", rcving, 0);
        check("rst_wen", w_enable, 0);
        check("rst_err", r_error, 0);
        check("rst_cnt", byte_count, 0);
        tick(3);

        // Clean two-byte packet.
        pkt_q = '{8'hA5, 8'h3C};
        run_pkt(SYNC_BYTE, 0);

        // Zero-byte packet is legal.
        pkt_q.delete();
        run_pkt(SYNC_BYTE, 0);

        // Bad SYNC: error two cycles after the strobe, then EIDLE, then recovery.
        start_pkt();
        for (int i = 0; i < 8; i++) shift_pulse();
        rcv_data      = 8'h81;
        byte_received = 1'b1;
        tick(1);
        byte_received = 1'b0;
        check("badsync_t1_err", r_error, 0);
        tick(1);
        check("badsync_t2_err", r_error, 1);
        check("badsync_rcving", rcving, 0);
        tick(3);
        edge_pulse();
        tick(1);
        check("eidle_err", r_error, 1);
        check("eidle_rcving", rcving, 0);
        edge_pulse();
        tick(1);
        check("resync_err", r_error, 0);
        check("resync_rcving", rcving, 1);
        tick(2);
        send_byte(SYNC_BYTE);
        end_pkt(1'b0, 0);

        // Partial byte at EOP, with and without a preceding full byte.
        pkt_q.delete();
        run_pkt(SYNC_BYTE, 3);
        pkt_q = '{8'hA5};
        run_pkt(SYNC_BYTE, 3);

        // Overflow past MAX_BYTES.
        pkt_q = '{8'hA5, 8'h3C, 8'h11};
        run_pkt(SYNC_BYTE, 0);

        // PID pass and fail patterns on byte 0.
        pkt_q = '{8'hE1};
        run_pkt(SYNC_BYTE, 0);
        pkt_q = '{8'hE2};
        run_pkt(SYNC_BYTE, 0);

        // EOP while still in SYNC.
        start_pkt();
        shift_pulse();
        shift_pulse();
        end_pkt(1'b1, 0);

        // Reset in the middle of a data byte.
        start_pkt();
        send_byte(SYNC_BYTE);
        exp_q.push_back(1);
        send_byte(8'hA5);
        check("prerst_cnt", byte_count, 1);
        repeat (3) shift_pulse();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_rcving", rcving, 0);
        check("midrst_err", r_error, 0);
        check("midrst_cnt", byte_count, 0);
        check("midrst_wen", w_enable, 0);
        tick(3);

        // Randomized packets.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] sync;
            int         nb;
            int         partial;
            sync    = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : SYNC_BYTE;
            nb      = int'($urandom_range(0, 3));
            partial = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            pkt_q.delete();
            for (int i = 0; i < nb; i++) begin
                logic [7:0] b;
                logic [3:0] lo;
                b  = 8'($urandom_range(0, 255));
                lo = b[3:0];
                if (i == 0 && $urandom_range(0, 1) == 1) b = {~lo, lo};
                pkt_q.push_back(b);
            end
            run_pkt(sync, partial);
            tick(int'($urandom_range(1, 4)));
        end

        tick(5);
        check("leftover_writes", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
